// File: rtl/iter_multdiv.sv
// Iterative 32-bit signed multiplier / divider: radix-2 shift-add multiply and
// restoring divide on magnitudes, fixed 33-cycle latency, registered outputs.
module iter_multdiv (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] data_operandA,
    input  logic [31:0] data_operandB,
    input  logic        ctrl_MULT,
    input  logic        ctrl_DIV,
    output logic [31:0] data_result,
    output logic        data_exception,
    output logic        data_resultRDY,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_r, state_next_s;
    logic [5:0]  cnt_r;
    logic [63:0] prod_r;
    logic [31:0] addend_r;
    logic        is_mul_r, neg_r, b_zero_r, div_ovf_r;
    logic [31:0] result_r;
    logic        exception_r, rdy_r, busy_r;

    logic        start_s, finish_s;
    logic [32:0] add_s, rem_s;
    logic [31:0] diff_s, signed_lo_s, res_s;
    logic        sub_ok_s, exc_s;
    logic [63:0] step_s;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        abs32 = v[31] ? (32'd0 - v) : v;
    endfunction

    // Magnitude of the product against the signed 32-bit range (|min| is one larger)
    function automatic logic mul_ovf(input logic [63:0] mag, input logic neg);
        mul_ovf = neg ? (mag > 64'h0000_0000_8000_0000) : (mag > 64'h0000_0000_7FFF_FFFF);
    endfunction

    assign start_s  = ctrl_MULT | ctrl_DIV;
    assign finish_s = (state_r == RUN) && (cnt_r == 6'd32);

    // Next-state logic; a start restarts from any state
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start_s) state_next_s = RUN;
                else         state_next_s = IDLE;
            end
            RUN: begin
                if (start_s)       state_next_s = RUN;
                else if (finish_s) state_next_s = DONE;
                else               state_next_s = RUN;
            end
            DONE: begin
                if (start_s) state_next_s = RUN;
                else         state_next_s = IDLE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    assign add_s    = {1'b0, prod_r[63:32]} + {1'b0, addend_r};
    assign rem_s    = {prod_r[63:32], prod_r[31]};
    assign sub_ok_s = (rem_s >= {1'b0, addend_r});
    assign diff_s   = rem_s[31:0] - addend_r;

    // One iteration: multiply adds into the upper half and shifts right; divide
    // shifts the remainder left and subtracts the divisor when it fits
    always_comb begin
        step_s = prod_r;
        if (is_mul_r) begin
            if (prod_r[0]) step_s = {add_s, prod_r[31:1]};
            else           step_s = {1'b0, prod_r[63:32], prod_r[31:1]};
        end else begin
            if (sub_ok_s) step_s = {diff_s, prod_r[30:0], 1'b1};
            else          step_s = {rem_s[31:0], prod_r[30:0], 1'b0};
        end
    end

    // Low word negation equals the low word of the 64-bit negation
    assign signed_lo_s = neg_r ? (32'd0 - prod_r[31:0]) : prod_r[31:0];

    // Final result and exception with sign correction
    always_comb begin
        res_s = signed_lo_s;
        exc_s = 1'b0;
        if (is_mul_r) begin
            res_s = signed_lo_s;
            exc_s = mul_ovf(prod_r, neg_r);
        end else if (b_zero_r) begin
            res_s = 32'd0;
            exc_s = 1'b1;
        end else begin
            res_s = signed_lo_s;
            exc_s = div_ovf_r;
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r     <= IDLE;
            cnt_r       <= 6'd0;
            prod_r      <= 64'd0;
            addend_r    <= 32'd0;
            is_mul_r    <= 1'b0;
            neg_r       <= 1'b0;
            b_zero_r    <= 1'b0;
            div_ovf_r   <= 1'b0;
            result_r    <= 32'd0;
            exception_r <= 1'b0;
            rdy_r       <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r <= state_next_s;
            if (start_s) begin
                is_mul_r  <= ctrl_MULT;
                addend_r  <= ctrl_MULT ? abs32(data_operandA) : abs32(data_operandB);
                prod_r    <= {32'd0, ctrl_MULT ? abs32(data_operandB) : abs32(data_operandA)};
                neg_r     <= data_operandA[31] ^ data_operandB[31];
                b_zero_r  <= (data_operandB == 32'd0);
                div_ovf_r <= (data_operandA == 32'h8000_0000) && (data_operandB == 32'hFFFF_FFFF);
                cnt_r     <= 6'd0;
                busy_r    <= 1'b1;
                rdy_r     <= 1'b0;
            end else if (finish_s) begin
                result_r    <= res_s;
                exception_r <= exc_s;
                busy_r      <= 1'b0;
                rdy_r       <= 1'b1;
            end else if (state_r == RUN) begin
                prod_r <= step_s;
                cnt_r  <= cnt_r + 6'd1;
                rdy_r  <= 1'b0;
            end else begin
                rdy_r <= 1'b0;
            end
        end
    end

    assign data_result    = result_r;
    assign data_exception = exception_r;
    assign data_resultRDY = rdy_r;
    assign busy           = busy_r;

endmodule

// File: tb/tb_iter_multdiv.sv
// Directed self-checking bench for iter_multdiv: latency, results, exceptions,
// abort by restart and reset mid-operation.
module tb_iter_multdiv;

    logic        clock = 1'b0;
    logic        reset;
    logic [31:0] data_operandA, data_operandB;
    logic        ctrl_MULT, ctrl_DIV;
    logic [31:0] data_result;
    logic        data_exception, data_resultRDY, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int pulses, rdy_edge, busy_n;

    iter_multdiv dut (
        .clock          (clock),
        .reset          (reset),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    always #5 clock = ~clock;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Called #1 after an edge; the next edge is the start edge k
    task automatic issue(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b);
        data_operandA = a;
        data_operandB = b;
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'hDEAD_BEEF;
        data_operandB = 32'h1234_5678;
    endtask

    // Observe n edges after the start edge, recording RDY pulses and busy cycles
    task automatic watch(input int n, output int p, output int e, output int bn);
        p  = 0;
        e  = -1;
        bn = 0;
        for (int j = 1; j <= n; j++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY) begin
                p++;
                e = j;
            end
            if (busy) bn++;
        end
    endtask

    task automatic run_op(input logic m, input logic d, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_r, input logic exp_e, input string tag);
        issue(m, d, a, b);
        check_val({tag, " busy_after_start"}, {31'd0, busy}, 32'd1);
        watch(34, pulses, rdy_edge, busy_n);
        check_val({tag, " rdy_pulses"}, pulses, 32'd1);
        check_val({tag, " rdy_edge"}, rdy_edge, 32'd33);
        check_val({tag, " busy_cycles_after_k"}, busy_n, 32'd32);
        check_val({tag, " result"}, data_result, exp_r);
        check_val({tag, " exception"}, {31'd0, data_exception}, {31'd0, exp_e});
    endtask

    initial begin
        reset         = 1'b1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'd0;
        data_operandB = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst result", data_result, 32'd0);
        check_val("rst exception", {31'd0, data_exception}, 32'd0);
        check_val("rst rdy", {31'd0, data_resultRDY}, 32'd0);
        check_val("rst busy", {31'd0, busy}, 32'd0);
        reset = 1'b0;

        run_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, "mul_7x-3");
        run_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1, "mul_ovf_2p32");
        run_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h8000_0000, 1'b1, "mul_-1xmin");
        run_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, "div_-7/2");
        run_op(1'b0, 1'b1, 32'd7, 32'd0, 32'h0000_0000, 1'b1, "div_by_zero");
        run_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, "div_min/-1");
        run_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF6, 32'hFFFF_FFF6, 1'b0, "div_100/-10");

        // Multiply aborted by a divide start at edge k+20
        issue(1'b1, 1'b0, 32'd5, 32'd6);
        watch(19, pulses, rdy_edge, busy_n);
        check_val("abort no_rdy_before_restart", pulses, 32'd0);
        check_val("abort result_held", data_result, 32'hFFFF_FFF6);
        issue(1'b0, 1'b1, 32'd20, 32'd4);
        watch(34, pulses, rdy_edge, busy_n);
        check_val("abort rdy_pulses", pulses, 32'd1);
        check_val("abort rdy_edge_after_restart", rdy_edge, 32'd33);
        check_val("abort result", data_result, 32'd5);
        check_val("abort exception", {31'd0, data_exception}, 32'd0);

        run_op(1'b1, 1'b1, 32'd6, 32'd3, 32'd18, 1'b0, "both_starts_mul_wins");

        // Reset at edge k+10, with a start at the same edge that must be dropped
        issue(1'b1, 1'b0, 32'd9, 32'd9);
        watch(9, pulses, rdy_edge, busy_n);
        check_val("midrst no_rdy", pulses, 32'd0);
        reset         = 1'b1;
        ctrl_MULT     = 1'b1;
        data_operandA = 32'd2;
        data_operandB = 32'd2;
        @(posedge clock);
        #1;
        check_val("midrst result", data_result, 32'd0);
        check_val("midrst exception", {31'd0, data_exception}, 32'd0);
        check_val("midrst rdy", {31'd0, data_resultRDY}, 32'd0);
        check_val("midrst busy_start_dropped", {31'd0, busy}, 32'd0);
        reset     = 1'b0;
        ctrl_MULT = 1'b0;
        run_op(1'b1, 1'b0, 32'd3, 32'd4, 32'd12, 1'b0, "mul_after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
